// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline control slice:
// stall-controller FSM states and the opcode map used by hazard/control units.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Wide enough for any legal MEM_TIMEOUT (up to 2^16-1)
    localparam int TO_W = 16;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous reset, synchronous clear and optional
// saturation at all-ones (SAT=1) instead of wrapping.
module sat_counter #(
    parameter int W   = 8,
    parameter bit SAT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && !(SAT && (&cnt)))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use stalls,
// branch flush and a multi-cycle data-memory handshake into stage controls.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             PC_stall_i,
    input  logic             IFID_stall_i,
    input  logic             IDEX_stall_i,
    input  logic             Branch_i,
    input  logic             MemRead_i,
    input  logic             MemWrite_i,
    input  logic             Mem_ack_i,
    output logic             Mem_req_o,
    output logic             PC_write_o,
    output logic             IFID_write_o,
    output logic             IDEX_write_o,
    output logic             EXMEM_write_o,
    output logic             IFID_flush_o,
    output logic             IDEX_bubble_o,
    output logic             MEMWB_bubble_o,
    output logic             Mem_timeout_o,
    output logic [CNT_W-1:0] Stall_cnt_o
);

    state_t          state, state_nxt;
    logic            mem_op, frozen, to_hit, wait_entry, to_en, stall_en;
    logic [TO_W-1:0] to_cnt;

    assign mem_op = MemRead_i | MemWrite_i;
    assign to_hit = (to_cnt == TO_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // An ack in WAIT releases the pipeline in the same cycle, so only
    // un-acked cycles are frozen.
    always_comb begin
        state_nxt = state;
        frozen    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_op && !Mem_ack_i) begin
                    state_nxt = ST_WAIT;
                    frozen    = 1'b1;
                end
            end
            ST_WAIT: begin
                if (Mem_ack_i) begin
                    state_nxt = ST_IDLE;
                end else begin
                    frozen = 1'b1;
                    if (to_hit)
                        state_nxt = ST_ERR;
                end
            end
            ST_ERR:  frozen = 1'b1;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        Mem_req_o      = 1'b0;
        PC_write_o     = 1'b0;
        IFID_write_o   = 1'b0;
        IDEX_write_o   = 1'b0;
        EXMEM_write_o  = 1'b0;
        IFID_flush_o   = 1'b0;
        IDEX_bubble_o  = 1'b0;
        MEMWB_bubble_o = 1'b0;
        if (!rst_i) begin
            Mem_req_o = (state == ST_IDLE) ? mem_op : (state == ST_WAIT);
            if (frozen) begin
                // Retiring instruction must not write back again while MEM holds
                MEMWB_bubble_o = 1'b1;
            end else begin
                PC_write_o    = ~PC_stall_i;
                IFID_write_o  = ~IFID_stall_i;
                IDEX_write_o  = 1'b1;
                IDEX_bubble_o = ~IDEX_stall_i;
                IFID_flush_o  = Branch_i & ~IFID_stall_i;
                EXMEM_write_o = 1'b1;
            end
        end
    end

    assign wait_entry = (state == ST_IDLE) && (state_nxt == ST_WAIT);
    assign to_en      = (state == ST_WAIT) && !Mem_ack_i;
    assign stall_en   = ~PC_write_o;

    sat_counter #(.W(TO_W), .SAT(1'b0)) u_timeout_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .clr (wait_entry),
        .en  (to_en),
        .cnt (to_cnt)
    );

    sat_counter #(.W(CNT_W), .SAT(1'b1)) u_stall_cnt (
        .clk (clk_i),
        .rst (rst_i),
        .clr (1'b0),
        .en  (stall_en),
        .cnt (Stall_cnt_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i)
            Mem_timeout_o <= 1'b0;
        else if (state == ST_WAIT && state_nxt == ST_ERR)
            Mem_timeout_o <= 1'b1;
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (MEM_TIMEOUT=4, CNT_W=4):
// each step queues its expected outputs, then pops and checks them mid-cycle.
module tb_pipeline_stall_controller;

    localparam int CW   = 4;
    localparam int NORM = 0;
    localparam int FROZ = 1;
    localparam int RST  = 2;

    logic clk = 1'b0;
    logic rst_i, PC_stall_i, IFID_stall_i, IDEX_stall_i, Branch_i;
    logic MemRead_i, MemWrite_i, Mem_ack_i;
    logic Mem_req_o, PC_write_o, IFID_write_o, IDEX_write_o, EXMEM_write_o;
    logic IFID_flush_o, IDEX_bubble_o, MEMWB_bubble_o, Mem_timeout_o;
    logic [CW-1:0] Stall_cnt_o;

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .PC_stall_i     (PC_stall_i),
        .IFID_stall_i   (IFID_stall_i),
        .IDEX_stall_i   (IDEX_stall_i),
        .Branch_i       (Branch_i),
        .MemRead_i      (MemRead_i),
        .MemWrite_i     (MemWrite_i),
        .Mem_ack_i      (Mem_ack_i),
        .Mem_req_o      (Mem_req_o),
        .PC_write_o     (PC_write_o),
        .IFID_write_o   (IFID_write_o),
        .IDEX_write_o   (IDEX_write_o),
        .EXMEM_write_o  (EXMEM_write_o),
        .IFID_flush_o   (IFID_flush_o),
        .IDEX_bubble_o  (IDEX_bubble_o),
        .MEMWB_bubble_o (MEMWB_bubble_o),
        .Mem_timeout_o  (Mem_timeout_o),
        .Stall_cnt_o    (Stall_cnt_o)
    );

    typedef struct packed {
        logic req, pcw, ifw, idw, emw, fl, bub, mwb, tmo;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad   = 0;
    int            stepno = 0;
    logic [CW-1:0] mcnt;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL step%0d %s observed=%0h expected=%0h", stepno, tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic pcs, input logic ifs, input logic idxs,
                        input logic br, input logic mr, input logic mw, input logic ack,
                        input int mode, input logic req, input logic tmo);
        exp_t e;
        exp_t o;
        stepno++;
        rst_i = r; PC_stall_i = pcs; IFID_stall_i = ifs; IDEX_stall_i = idxs;
        Branch_i = br; MemRead_i = mr; MemWrite_i = mw; Mem_ack_i = ack;
        e = '0;
        e.req = req;
        e.tmo = tmo;
        e.cnt = mcnt;
        if (mode == NORM) begin
            e.pcw = ~pcs; e.ifw = ~ifs; e.idw = 1'b1; e.emw = 1'b1;
            e.bub = ~idxs; e.fl = br & ~ifs; e.mwb = 1'b0;
        end else if (mode == FROZ) begin
            e.mwb = 1'b1;
        end
        sb.push_back(e);
        @(negedge clk);
        o = sb.pop_front();
        chk("mem_req",     {7'b0, Mem_req_o},      {7'b0, o.req});
        chk("pc_write",    {7'b0, PC_write_o},     {7'b0, o.pcw});
        chk("ifid_write",  {7'b0, IFID_write_o},   {7'b0, o.ifw});
        chk("idex_write",  {7'b0, IDEX_write_o},   {7'b0, o.idw});
        chk("exmem_write", {7'b0, EXMEM_write_o},  {7'b0, o.emw});
        chk("ifid_flush",  {7'b0, IFID_flush_o},   {7'b0, o.fl});
        chk("idex_bubble", {7'b0, IDEX_bubble_o},  {7'b0, o.bub});
        chk("memwb_bubble",{7'b0, MEMWB_bubble_o}, {7'b0, o.mwb});
        chk("mem_timeout", {7'b0, Mem_timeout_o},  {7'b0, o.tmo});
        chk("stall_cnt",   {4'b0, Stall_cnt_o},    {4'b0, o.cnt});
        @(posedge clk);
        #1;
        if (r)
            mcnt = '0;
        else if (!o.pcw && mcnt != '1)
            mcnt = mcnt + 1'b1;
    endtask

    initial begin
        rst_i = 1'b1; PC_stall_i = 0; IFID_stall_i = 0; IDEX_stall_i = 1;
        Branch_i = 0; MemRead_i = 0; MemWrite_i = 0; Mem_ack_i = 0;
        mcnt = '0;
        @(posedge clk);
        #1;
        //   r pcs ifs idx br mr mw ack  mode  req tmo
        step(1, 0, 0, 1, 0, 1, 0, 0, RST,  0, 0);   // reset holds outputs low
        step(0, 0, 0, 1, 0, 0, 0, 0, NORM, 0, 0);   // idle, free-running
        step(0, 1, 1, 0, 0, 0, 0, 0, NORM, 0, 0);   // load-use hazard
        step(0, 0, 0, 1, 1, 0, 0, 0, NORM, 0, 0);   // branch flush
        step(0, 0, 1, 1, 1, 0, 0, 0, NORM, 0, 0);   // branch while IF/ID held
        step(0, 0, 0, 1, 0, 0, 0, 1, NORM, 0, 0);   // stray ack ignored
        // 3-cycle read, branch pending in ID during the freeze
        step(0, 1, 0, 0, 1, 1, 0, 0, FROZ, 1, 0);
        step(0, 1, 0, 0, 1, 1, 0, 0, FROZ, 1, 0);
        step(0, 1, 0, 0, 1, 1, 0, 0, FROZ, 1, 0);
        step(0, 0, 0, 1, 1, 1, 0, 1, NORM, 1, 0);   // ack: release, flush re-evaluated
        step(0, 0, 0, 1, 0, 1, 0, 1, NORM, 1, 0);   // same-cycle ack, no stall
        step(0, 0, 0, 1, 0, 0, 0, 0, NORM, 0, 0);   // still idle
        // write with no ack -> timeout after 4 WAIT cycles
        step(0, 0, 0, 1, 0, 0, 1, 0, FROZ, 1, 0);
        step(0, 0, 0, 1, 0, 0, 1, 0, FROZ, 1, 0);
        step(0, 0, 0, 1, 0, 0, 1, 0, FROZ, 1, 0);
        step(0, 0, 0, 1, 0, 0, 1, 0, FROZ, 1, 0);
        step(0, 0, 0, 1, 0, 0, 1, 0, FROZ, 1, 0);
        step(0, 0, 0, 1, 0, 0, 1, 0, FROZ, 0, 1);   // ERR
        step(0, 0, 0, 1, 1, 0, 0, 1, FROZ, 0, 1);   // ack in ERR ignored
        step(1, 0, 0, 1, 0, 1, 0, 0, RST,  0, 1);   // reset leaves ERR
        step(0, 0, 0, 1, 0, 0, 0, 0, NORM, 0, 0);
        // reset on WAIT cycle 2
        step(0, 0, 0, 1, 0, 1, 0, 0, FROZ, 1, 0);
        step(0, 0, 0, 1, 0, 1, 0, 0, FROZ, 1, 0);
        step(1, 0, 0, 1, 0, 1, 0, 0, RST,  0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, NORM, 0, 0);   // back in IDLE, count 0
        // stall-counter saturation
        for (int i = 0; i < 20; i++)
            step(0, 1, 0, 1, 0, 0, 0, 0, NORM, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, NORM, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges the load-use hazard requests (PC/IF-ID/ID-EX stall lines), the branch-taken flush from ID, and a multi-cycle data-memory handshake from the EX/MEM stage into per-stage write-enable, flush and bubble controls. A small FSM freezes the whole pipeline while a data-memory access is outstanding. A watchdog and a stall-cycle counter support debug.

## Interface
- MEM_TIMEOUT, 255: max cycles in WAIT before declaring a memory timeout (1..2^16-1).
- CNT_W, 32: width of the stall-cycle counter.

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- PC_stall_i  in  1  1 = hold PC (load-use hazard)
- IFID_stall_i  in  1  1 = hold IF/ID
- IDEX_stall_i  in  1  hazard-unit encoding: 1 = pass control normally, 0 = insert bubble
- Branch_i  in  1  branch resolved taken in ID
- MemRead_i, MemWrite_i  in  1 each  EX/MEM instruction accesses data memory
- Mem_ack_i  in  1  data memory completes the current access this cycle
- Mem_req_o  out  1  data-memory request
- PC_write_o, IFID_write_o, IDEX_write_o, EXMEM_write_o  out  1 each  stage-register write enables
- IFID_flush_o  out  1  clear IF/ID to NOP on the next edge
- IDEX_bubble_o  out  1  load control-zero bubble into ID/EX
- MEMWB_bubble_o  out  1  load bubble into MEM/WB
- Mem_timeout_o  out  1  sticky timeout flag
- Stall_cnt_o  out  CNT_W  saturating count of cycles with PC_write_o=0

## Operation
- FSM states: IDLE, WAIT, ERR. Reset state is IDLE.
- **mem_op** = MemRead_i | MemWrite_i.
- **Mem_req_o** = mem_op in IDLE; 1 in WAIT; 0 in ERR.
- **IDLE transitions:**
  - mem_op & ~Mem_ack_i → WAIT (memory stall).
  - mem_op & Mem_ack_i → stay IDLE (single-cycle access, no stall).
- **WAIT transitions:**
  - Mem_ack_i → IDLE, and the pipeline advances in that same cycle.
  - No ack and timeout counter = MEM_TIMEOUT-1 → ERR.
- **ERR:** absorbing until reset.
- **Normal mode** (IDLE without memory stall, or WAIT with ack):
  - PC_write_o=~PC_stall_i
  - IFID_write_o=~IFID_stall_i
  - IDEX_write_o=1
  - IDEX_bubble_o=~IDEX_stall_i
  - IFID_flush_o=Branch_i & ~IFID_stall_i
  - EXMEM_write_o=1
  - MEMWB_bubble_o=0
- **Frozen mode** (memory stall, or ERR):
  - All *_write_o=0.
  - IFID_flush_o=0, IDEX_bubble_o=0.
  - MEMWB_bubble_o=1, so the retiring instruction writes back exactly once.
- **Priority:** memory stall > load-use hazard > branch flush. A flush is never issued while IF/ID is held.
- **Timeout counter:** cleared on entry to WAIT, increments each WAIT cycle without ack.
- **Mem_timeout_o:** set on entry to ERR; cleared only by reset.
- **Stall_cnt_o:** increments in every cycle with PC_write_o=0 and rst_i=0. It saturates at 2^CNT_W-1 and never wraps.

## Timing
- All outputs are combinational from state plus inputs. Only the state, the counters and Mem_timeout_o are registered.
- A memory access acknowledged in cycle k of WAIT adds exactly k stall cycles. An ack in the same cycle as the request adds 0.
- **While rst_i=1:**
  - All *_write_o, IFID_flush_o, IDEX_bubble_o, MEMWB_bubble_o and Mem_req_o are 0.
  - After the edge: state IDLE, both counters 0, Mem_timeout_o 0.
- Reset mid-WAIT or in ERR aborts the access; Mem_req_o drops in the reset cycle.
- Mem_ack_i in IDLE without mem_op, or in ERR, is ignored.
- Branch_i together with a memory stall: the flush is suppressed. It is re-evaluated when the pipeline releases, because ID still holds the branch.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state enum (IDLE/WAIT/ERR);
  - the MIPS opcode constants (R-type 000000, addi 001000, beq 000100, lw, sw) shared with the hazard and control units.
- One sub-module, sat_counter (parameterized width, enable, clear, saturate flag). It is instantiated twice: once for the timeout counter, once for Stall_cnt_o.
- The FSM and output decode stay in the top module.

## Test plan
- **Load-use hazard:** IDLE, no mem_op, PC_stall_i=IFID_stall_i=1, IDEX_stall_i=0 → PC_write_o=0, IFID_write_o=0, IDEX_bubble_o=1, EXMEM_write_o=1; Stall_cnt_o increments by 1.
- **Branch flush:** Branch_i=1, no stalls → IFID_flush_o=1 for one cycle. Repeat with IFID_stall_i=1 → IFID_flush_o=0.
- **3-cycle memory access:** MemRead_i=1, Mem_ack_i arrives on the 3rd WAIT cycle → Mem_req_o=1 throughout, the pipeline is frozen for 3 cycles with MEMWB_bubble_o=1, and all writes enabled in the ack cycle. Also drive the same stimulus with ack in the same cycle as the request → 0 stall cycles.
- **Timeout:** MEM_TIMEOUT=4, no ack → ERR after 4 WAIT cycles; Mem_timeout_o=1 sticky, Mem_req_o=0, all writes 0 until rst_i.
- **Reset mid-WAIT:** rst_i=1 on WAIT cycle 2 → Mem_req_o=0 that cycle; next cycle IDLE with Stall_cnt_o=0.
- **Saturation:** CNT_W=4, hold PC_stall_i=1 for 20 cycles → Stall_cnt_o stops at 15.
